// File: rtl/reg_cmd_seq_if.sv
// Handshake and command bus between a tile requester and reg_cmd_seq.
interface reg_cmd_seq_if #(
    parameter int unsigned CW = 5
);
    logic          start;
    logic          hold;
    logic [1:0]    reg_array_cmd;
    logic          buf_rd_en;
    logic          fifo_rd_en;
    logic          pe_valid;
    logic [CW-1:0] kx;
    logic [CW-1:0] ky;
    logic [CW-1:0] row_idx;
    logic          busy;
    logic          done;

    // Requester side: issues tile requests and stalls, observes the sequence.
    modport master (
        output start, hold,
        input  reg_array_cmd, buf_rd_en, fifo_rd_en, pe_valid,
        input  kx, ky, row_idx, busy, done
    );

    // Sequencer side.
    modport slave (
        input  start, hold,
        output reg_array_cmd, buf_rd_en, fifo_rd_en, pe_valid,
        output kx, ky, row_idx, busy, done
    );
endinterface

// File: rtl/reg_cmd_seq.sv
// Register-array command sequencer: walks kx (inner), ky, row over one tile,
// issuing load-buffer / load-fifo / shift commands and flagging PE-valid data
// one cycle later. All outputs come straight from flops.
module reg_cmd_seq #(
    parameter int unsigned KSIZE = 3,
    parameter int unsigned ROWS  = 16,
    parameter int unsigned CW    = 5
) (
    input  logic         clk,
    input  logic         rst,
    reg_cmd_seq_if.slave bus
);
    localparam logic [1:0]    CMD_LOAD_BUF  = 2'b00;
    localparam logic [1:0]    CMD_SHIFT     = 2'b01;
    localparam logic [1:0]    CMD_LOAD_FIFO = 2'b10;
    localparam logic [1:0]    CMD_IDLE      = 2'b11;
    localparam logic [CW-1:0] KMAX          = CW'(KSIZE - 1);
    localparam logic [CW-1:0] RMAX          = CW'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t        r_state, w_nxt_state;

    // Counters hold the coordinates of the next command to issue.
    logic [CW-1:0] r_kx_cnt, r_ky_cnt, r_row_cnt;
    logic [CW-1:0] w_nxt_kx_cnt, w_nxt_ky_cnt, w_nxt_row_cnt;
    logic          r_end, w_nxt_end;

    // Coordinates of the command currently on reg_array_cmd.
    logic [CW-1:0] r_iss_kx, r_iss_ky, r_iss_row;
    logic [CW-1:0] w_nxt_iss_kx, w_nxt_iss_ky, w_nxt_iss_row;

    logic [1:0]    r_cmd, w_nxt_cmd;
    logic          r_buf_rd_en, w_nxt_buf_rd_en;
    logic          r_fifo_rd_en, w_nxt_fifo_rd_en;
    logic          r_pe_valid, w_nxt_pe_valid;
    logic [CW-1:0] r_kx, r_ky, r_row_idx;
    logic [CW-1:0] w_nxt_kx, w_nxt_ky, w_nxt_row_idx;
    logic          r_busy, w_nxt_busy;
    logic          r_done, w_nxt_done;

    logic          w_issue;
    logic [CW-1:0] w_cur_kx, w_cur_ky, w_cur_row;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Next state, command issue, counter advance and output pipeline.
    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_kx_cnt     = r_kx_cnt;
        w_nxt_ky_cnt     = r_ky_cnt;
        w_nxt_row_cnt    = r_row_cnt;
        w_nxt_end        = r_end;
        w_nxt_iss_kx     = r_iss_kx;
        w_nxt_iss_ky     = r_iss_ky;
        w_nxt_iss_row    = r_iss_row;
        w_nxt_cmd        = CMD_IDLE;
        w_nxt_buf_rd_en  = 1'b0;
        w_nxt_fifo_rd_en = 1'b0;
        w_nxt_busy       = r_busy;
        w_nxt_done       = 1'b0;
        w_nxt_pe_valid   = (r_cmd != CMD_IDLE);
        w_nxt_kx         = r_kx;
        w_nxt_ky         = r_ky;
        w_nxt_row_idx    = r_row_idx;
        w_issue          = 1'b0;

        // A fresh tile starts from all-zero coordinates.
        w_cur_kx  = (r_state == S_IDLE) ? '0 : r_kx_cnt;
        w_cur_ky  = (r_state == S_IDLE) ? '0 : r_ky_cnt;
        w_cur_row = (r_state == S_IDLE) ? '0 : r_row_cnt;

        if (r_cmd != CMD_IDLE) begin
            w_nxt_kx      = r_iss_kx;
            w_nxt_ky      = r_iss_ky;
            w_nxt_row_idx = r_iss_row;
        end

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_nxt_state   = S_RUN;
                    w_nxt_busy    = 1'b1;
                    w_nxt_end     = 1'b0;
                    w_nxt_kx_cnt  = '0;
                    w_nxt_ky_cnt  = '0;
                    w_nxt_row_cnt = '0;
                    w_issue       = !bus.hold;
                end
            end
            S_RUN: begin
                // Once every command is out, flush regardless of hold.
                if (r_end) begin
                    w_nxt_state = S_FLUSH;
                    w_nxt_done  = 1'b1;
                end else begin
                    w_issue = !bus.hold;
                end
            end
            S_FLUSH: begin
                w_nxt_state = S_IDLE;
                w_nxt_busy  = 1'b0;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase

        if (w_issue) begin
            w_nxt_iss_kx  = w_cur_kx;
            w_nxt_iss_ky  = w_cur_ky;
            w_nxt_iss_row = w_cur_row;
            if (w_cur_kx != '0) begin
                w_nxt_cmd = CMD_SHIFT;
            end else if (w_cur_ky == '0) begin
                w_nxt_cmd       = CMD_LOAD_BUF;
                w_nxt_buf_rd_en = 1'b1;
            end else begin
                w_nxt_cmd        = CMD_LOAD_FIFO;
                w_nxt_fifo_rd_en = 1'b1;
            end

            if (w_cur_kx == KMAX) begin
                w_nxt_kx_cnt = '0;
                if (w_cur_ky == KMAX) begin
                    w_nxt_ky_cnt = '0;
                    if (w_cur_row == RMAX) begin
                        w_nxt_row_cnt = '0;
                        w_nxt_end     = 1'b1;
                    end else begin
                        w_nxt_row_cnt = w_cur_row + CW'(1);
                    end
                end else begin
                    w_nxt_ky_cnt = w_cur_ky + CW'(1);
                end
            end else begin
                w_nxt_kx_cnt = w_cur_kx + CW'(1);
            end
        end
    end

    // Counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kx_cnt     <= '0;
            r_ky_cnt     <= '0;
            r_row_cnt    <= '0;
            r_end        <= 1'b0;
            r_iss_kx     <= '0;
            r_iss_ky     <= '0;
            r_iss_row    <= '0;
            r_cmd        <= CMD_IDLE;
            r_buf_rd_en  <= 1'b0;
            r_fifo_rd_en <= 1'b0;
            r_pe_valid   <= 1'b0;
            r_kx         <= '0;
            r_ky         <= '0;
            r_row_idx    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_kx_cnt     <= w_nxt_kx_cnt;
            r_ky_cnt     <= w_nxt_ky_cnt;
            r_row_cnt    <= w_nxt_row_cnt;
            r_end        <= w_nxt_end;
            r_iss_kx     <= w_nxt_iss_kx;
            r_iss_ky     <= w_nxt_iss_ky;
            r_iss_row    <= w_nxt_iss_row;
            r_cmd        <= w_nxt_cmd;
            r_buf_rd_en  <= w_nxt_buf_rd_en;
            r_fifo_rd_en <= w_nxt_fifo_rd_en;
            r_pe_valid   <= w_nxt_pe_valid;
            r_kx         <= w_nxt_kx;
            r_ky         <= w_nxt_ky;
            r_row_idx    <= w_nxt_row_idx;
            r_busy       <= w_nxt_busy;
            r_done       <= w_nxt_done;
        end
    end

    assign bus.reg_array_cmd = r_cmd;
    assign bus.buf_rd_en     = r_buf_rd_en;
    assign bus.fifo_rd_en    = r_fifo_rd_en;
    assign bus.pe_valid      = r_pe_valid;
    assign bus.kx            = r_kx;
    assign bus.ky            = r_ky;
    assign bus.row_idx       = r_row_idx;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;

endmodule

// File: tb/tb_reg_cmd_seq.sv
// Directed bench for reg_cmd_seq: three instances with different kernel/row
// sizes share one clock and reset.
module tb_reg_cmd_seq;
    localparam int unsigned CW = 5;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    logic [1:0] pat [9];

    reg_cmd_seq_if #(.CW(CW)) if_a ();
    reg_cmd_seq_if #(.CW(CW)) if_b ();
    reg_cmd_seq_if #(.CW(CW)) if_c ();

    reg_cmd_seq #(.KSIZE(3), .ROWS(2), .CW(CW)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    reg_cmd_seq #(.KSIZE(3), .ROWS(1), .CW(CW)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    reg_cmd_seq #(.KSIZE(1), .ROWS(3), .CW(CW)) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_total++; if (if_a.reg_array_cmd !== 2'b11) $display("FAIL reset_cmd_a: got %b want 11", if_a.reg_array_cmd); else n_pass++;
        n_total++; if (if_b.reg_array_cmd !== 2'b11) $display("FAIL reset_cmd_b: got %b want 11", if_b.reg_array_cmd); else n_pass++;
        n_total++; if (if_c.reg_array_cmd !== 2'b11) $display("FAIL reset_cmd_c: got %b want 11", if_c.reg_array_cmd); else n_pass++;
        n_total++; if ({if_a.buf_rd_en, if_a.fifo_rd_en, if_a.pe_valid, if_a.busy, if_a.done} !== 5'b0)
            $display("FAIL reset_flags_a: got %b want 00000", {if_a.buf_rd_en, if_a.fifo_rd_en, if_a.pe_valid, if_a.busy, if_a.done}); else n_pass++;
        n_total++; if ({if_a.kx, if_a.ky, if_a.row_idx} !== 15'b0)
            $display("FAIL reset_coords_a: got %h want 0", {if_a.kx, if_a.ky, if_a.row_idx}); else n_pass++;
        rst = 1'b0;
        tick();
        // hold alone in idle must not start anything
        if_a.hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_total++; if (if_a.reg_array_cmd !== 2'b11 || if_a.busy !== 1'b0)
                $display("FAIL idle_hold c%0d: got cmd %b busy %b want 11 0", c, if_a.reg_array_cmd, if_a.busy); else n_pass++;
        end
        if_a.hold = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [1:0] exp_cmd;
        int idx;
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            exp_cmd = (c <= 18) ? pat[(c - 1) % 9] : 2'b11;
            n_total++; if (if_a.reg_array_cmd !== exp_cmd) $display("FAIL basic_cmd c%0d: got %b want %b", c, if_a.reg_array_cmd, exp_cmd); else n_pass++;
            n_total++; if (if_a.buf_rd_en !== (c == 1 || c == 10)) $display("FAIL basic_buf c%0d: got %b", c, if_a.buf_rd_en); else n_pass++;
            n_total++; if (if_a.fifo_rd_en !== (exp_cmd == 2'b10)) $display("FAIL basic_fifo c%0d: got %b", c, if_a.fifo_rd_en); else n_pass++;
            n_total++; if (if_a.pe_valid !== (c >= 2 && c <= 19)) $display("FAIL basic_pe c%0d: got %b", c, if_a.pe_valid); else n_pass++;
            n_total++; if (if_a.busy !== (c <= 19)) $display("FAIL basic_busy c%0d: got %b", c, if_a.busy); else n_pass++;
            n_total++; if (if_a.done !== (c == 19)) $display("FAIL basic_done c%0d: got %b", c, if_a.done); else n_pass++;
            if (c >= 2 && c <= 19) begin
                idx = c - 2;
                n_total++; if (if_a.kx !== CW'(idx % 3) || if_a.ky !== CW'((idx / 3) % 3) || if_a.row_idx !== CW'(idx / 9))
                    $display("FAIL basic_coords c%0d: got %0d/%0d/%0d want %0d/%0d/%0d", c, if_a.kx, if_a.ky, if_a.row_idx,
                             idx % 3, (idx / 3) % 3, idx / 9); else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_hold();
        logic [1:0] exp_cmd [13];
        logic       exp_pe  [13];
        exp_cmd = '{2'b00, 2'b01, 2'b11, 2'b11, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11, 2'b11};
        exp_pe  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        if_b.start = 1'b1;
        tick();
        if_b.start = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            n_total++; if (if_b.reg_array_cmd !== exp_cmd[c-1]) $display("FAIL hold_cmd c%0d: got %b want %b", c, if_b.reg_array_cmd, exp_cmd[c-1]); else n_pass++;
            n_total++; if (if_b.pe_valid !== exp_pe[c-1]) $display("FAIL hold_pe c%0d: got %b want %b", c, if_b.pe_valid, exp_pe[c-1]); else n_pass++;
            n_total++; if (if_b.done !== (c == 12)) $display("FAIL hold_done c%0d: got %b", c, if_b.done); else n_pass++;
            if (c == 3 || c == 4) begin
                n_total++; if (if_b.buf_rd_en !== 1'b0 || if_b.fifo_rd_en !== 1'b0)
                    $display("FAIL hold_strobes c%0d: got %b%b want 00", c, if_b.buf_rd_en, if_b.fifo_rd_en); else n_pass++;
            end
            if (c == 6) begin
                n_total++; if (if_b.kx !== CW'(2) || if_b.ky !== CW'(0))
                    $display("FAIL hold_resume_kx: got kx %0d ky %0d want 2 0", if_b.kx, if_b.ky); else n_pass++;
            end
            if_b.hold = (c == 2 || c == 3);
            tick();
        end
        if_b.hold = 1'b0;
    endtask

    task automatic test_start_ignored();
        int n_done;
        n_done = 0;
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            if (c <= 18) begin
                n_total++; if (if_a.reg_array_cmd !== pat[(c - 1) % 9])
                    $display("FAIL restart_cmd c%0d: got %b want %b", c, if_a.reg_array_cmd, pat[(c - 1) % 9]); else n_pass++;
            end
            if (if_a.done === 1'b1) n_done++;
            if (c == 19) begin
                n_total++; if (if_a.done !== 1'b1) $display("FAIL restart_done_c19: got %b want 1", if_a.done); else n_pass++;
            end
            if_a.start = (c == 5);
            tick();
        end
        if_a.start = 1'b0;
        n_total++; if (n_done != 1) $display("FAIL restart_done_count: got %0d want 1", n_done); else n_pass++;
        n_total++; if (if_a.busy !== 1'b0) $display("FAIL restart_busy_end: got %b want 0", if_a.busy); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n_done;
        n_done = 0;
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        n_total++; if (if_a.pe_valid !== 1'b1 || if_a.busy !== 1'b1)
            $display("FAIL rstmid_pre: got pe %b busy %b want 1 1", if_a.pe_valid, if_a.busy); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if (if_a.reg_array_cmd !== 2'b11) $display("FAIL rstmid_cmd: got %b want 11", if_a.reg_array_cmd); else n_pass++;
        n_total++; if ({if_a.buf_rd_en, if_a.fifo_rd_en, if_a.pe_valid, if_a.busy, if_a.done} !== 5'b0)
            $display("FAIL rstmid_flags: got %b want 00000", {if_a.buf_rd_en, if_a.fifo_rd_en, if_a.pe_valid, if_a.busy, if_a.done}); else n_pass++;
        n_total++; if ({if_a.kx, if_a.ky, if_a.row_idx} !== 15'b0)
            $display("FAIL rstmid_coords: got %h want 0", {if_a.kx, if_a.ky, if_a.row_idx}); else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        n_total++; if (if_a.reg_array_cmd !== 2'b00 || if_a.buf_rd_en !== 1'b1 || if_a.busy !== 1'b1)
            $display("FAIL rstmid_first: got cmd %b buf %b busy %b want 00 1 1", if_a.reg_array_cmd, if_a.buf_rd_en, if_a.busy); else n_pass++;
        tick();
        n_total++; if (if_a.pe_valid !== 1'b1 || if_a.row_idx !== CW'(0) || if_a.kx !== CW'(0) || if_a.ky !== CW'(0))
            $display("FAIL rstmid_fresh: got pe %b row %0d kx %0d ky %0d want 1 0 0 0", if_a.pe_valid, if_a.row_idx, if_a.kx, if_a.ky); else n_pass++;
        for (int c = 2; c <= 21; c++) begin
            if (if_a.done === 1'b1) begin
                n_done++;
                n_total++; if (c != 19) $display("FAIL rstmid_done_cycle: got %0d want 19", c); else n_pass++;
            end
            tick();
        end
        n_total++; if (n_done != 1) $display("FAIL rstmid_done_count: got %0d want 1", n_done); else n_pass++;
    endtask

    task automatic test_ksize1();
        if_c.start = 1'b1;
        tick();
        if_c.start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            n_total++; if (if_c.reg_array_cmd !== ((c <= 3) ? 2'b00 : 2'b11)) $display("FAIL k1_cmd c%0d: got %b", c, if_c.reg_array_cmd); else n_pass++;
            n_total++; if (if_c.buf_rd_en !== (c <= 3)) $display("FAIL k1_buf c%0d: got %b", c, if_c.buf_rd_en); else n_pass++;
            n_total++; if (if_c.pe_valid !== (c >= 2 && c <= 4)) $display("FAIL k1_pe c%0d: got %b", c, if_c.pe_valid); else n_pass++;
            n_total++; if (if_c.done !== (c == 4)) $display("FAIL k1_done c%0d: got %b", c, if_c.done); else n_pass++;
            n_total++; if (if_c.busy !== (c <= 4)) $display("FAIL k1_busy c%0d: got %b", c, if_c.busy); else n_pass++;
            if (c >= 2 && c <= 4) begin
                n_total++; if (if_c.row_idx !== CW'(c - 2) || if_c.kx !== CW'(0))
                    $display("FAIL k1_row c%0d: got row %0d kx %0d want %0d 0", c, if_c.row_idx, if_c.kx, c - 2); else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_start_hold();
        if_a.hold  = 1'b1;
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        for (int c = 1; c <= 23; c++) begin
            if (c <= 3) begin
                n_total++; if (if_a.reg_array_cmd !== 2'b11 || if_a.busy !== 1'b1 || if_a.pe_valid !== 1'b0)
                    $display("FAIL shold_wait c%0d: got cmd %b busy %b pe %b want 11 1 0", c, if_a.reg_array_cmd, if_a.busy, if_a.pe_valid); else n_pass++;
            end else if (c <= 21) begin
                n_total++; if (if_a.reg_array_cmd !== pat[(c - 4) % 9])
                    $display("FAIL shold_cmd c%0d: got %b want %b", c, if_a.reg_array_cmd, pat[(c - 4) % 9]); else n_pass++;
            end
            if (c == 4) begin
                n_total++; if (if_a.buf_rd_en !== 1'b1) $display("FAIL shold_buf: got %b want 1", if_a.buf_rd_en); else n_pass++;
            end
            n_total++; if (if_a.done !== (c == 22)) $display("FAIL shold_done c%0d: got %b", c, if_a.done); else n_pass++;
            n_total++; if (if_a.busy !== (c <= 22)) $display("FAIL shold_busy c%0d: got %b", c, if_a.busy); else n_pass++;
            if (c == 3) if_a.hold = 1'b0;
            tick();
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        pat = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
        rst = 1'b1;
        if_a.start = 1'b0; if_a.hold = 1'b0;
        if_b.start = 1'b0; if_b.hold = 1'b0;
        if_c.start = 1'b0; if_c.hold = 1'b0;
        test_reset();
        test_basic();
        test_hold();
        test_start_ignored();
        test_reset_mid();
        test_ksize1();
        test_start_hold();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/reg_cmd_seq.md
REG_CMD_SEQ -- requirements
Module: reg_cmd_seq

Interface
REQ-001 SHALL have parameter KSIZE, default 3, kernel width and height (1..7).
REQ-002 SHALL have parameter ROWS, default 16, output rows per tile (>=1).
REQ-003 SHALL have parameter CW, default 5, counter width; SHALL hold 2^CW > max(KSIZE, ROWS).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle tile request.
REQ-007 SHALL have port hold  input  1  downstream stall; freezes sequence.
REQ-008 SHALL have port reg_array_cmd  output  2  command to register array: 00 load buffer, 01 shift, 10 load fifo, 11 idle.
REQ-009 SHALL have port buf_rd_en  output  1  buffer-row fetch strobe.
REQ-010 SHALL have port fifo_rd_en  output  1  line-fifo pop strobe.
REQ-011 SHALL have port pe_valid  output  1  register-array contents valid for PEs.
REQ-012 SHALL have port kx  output  CW  kernel column of the data flagged by pe_valid.
REQ-013 SHALL have port ky  output  CW  kernel row of the data flagged by pe_valid.
REQ-014 SHALL have port row_idx  output  CW  output row of the data flagged by pe_valid.
REQ-015 SHALL have port busy  output  1  tile in progress.
REQ-016 SHALL have port done  output  1  one-cycle tile-complete pulse.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 The FSM SHALL have exactly the states IDLE, RUN and FLUSH.
REQ-019 In IDLE, start=1 SHALL clear the counters, enter RUN and set busy=1 on the next edge.
REQ-020 In RUN, each cycle with hold=0 SHALL issue one command and advance the counters in the order kx (inner), ky, row.
REQ-021 For kx=0, ky=0 the command SHALL be 00, with buf_rd_en=1 in the same cycle.
REQ-022 For kx=0, ky>0 the command SHALL be 10, with fifo_rd_en=1 in the same cycle.
REQ-023 For kx>0 the command SHALL be 01.
REQ-024 KSIZE=1 SHALL issue only 00 commands, one per row.
REQ-025 Each cycle in RUN with hold=1 SHALL output cmd=11, buf_rd_en=0 and fifo_rd_en=0, and SHALL freeze all counters.
REQ-026 A hold that is still high when start is accepted SHALL delay the first command until hold falls.
REQ-027 pe_valid SHALL assert exactly one cycle after each non-11 command.
REQ-028 kx, ky and row_idx SHALL carry the counter values of that command, aligned with pe_valid.
REQ-029 After the command with kx=ky=KSIZE-1 and row=ROWS-1, the FSM SHALL enter FLUSH; the command output in FLUSH SHALL be 11.
REQ-030 In FLUSH, pe_valid SHALL be 1 for the last data and done SHALL be 1 for one cycle; the FSM SHALL then return to IDLE with busy=0.
REQ-031 hold SHALL NOT delay FLUSH.
REQ-032 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-033 hold in IDLE SHALL have no effect.
REQ-034 Total commands per tile SHALL be ROWS*KSIZE*KSIZE.
REQ-035 With no hold, done SHALL occur ROWS*KSIZE*KSIZE+1 cycles after the first command.

Reset
REQ-036 rst=1 SHALL immediately force state IDLE, reg_array_cmd=11, and buf_rd_en, fifo_rd_en, pe_valid, busy, done, kx, ky, row_idx all =0, independent of clk.
REQ-037 Reset mid-tile SHALL abandon the tile; the first start after rst falls SHALL begin a fresh tile at row 0.

Verification
REQ-038 KSIZE=3, ROWS=2, start pulse, hold=0 -> cmds 00,01,01,10,01,01,10,01,01 repeated twice; buf_rd_en on cycles 1 and 10; done on cycle 19; busy high on cycles 1-19.
REQ-039 KSIZE=3, ROWS=1, hold=1 for 2 cycles after the 2nd command -> cmd 11 for 2 cycles with no pe_valid; sequence resumes with a shift at kx=2; done delayed by 2 cycles.
REQ-040 start pulsed again mid-tile -> no change in sequence; exactly one done.
REQ-041 rst asserted at cycle 5 of a tile -> outputs take reset values immediately; a new start yields a fresh 00 with row_idx=0.
REQ-042 KSIZE=1, ROWS=3 -> cmds 00,00,00; pe_valid with row_idx 0,1,2; done on cycle 4.
REQ-043 start with hold=1 held for 3 cycles -> busy=1, cmd=11 throughout; the first 00 is issued on the cycle hold falls.
